// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone B3 master engine. Accepts one request at a time from the core
//   side and runs an incrementing (linear) burst of 1..MAX_BEATS beats. Every
//   strobe cycle without ack/err is counted by a watchdog. After TIMEOUT_CYC
//   consecutive stalled cycles the burst is aborted.
//
// Ports
//   i_clk, quick_n_reset      clock, asynchronous active-low reset
//   i_req / o_req_ready       request handshake (ready only in IDLE)
//   i_req_we/adr/sel/beats    request attributes, latched on acceptance
//   i_wdata / o_wdata_pop     write data source (FWFT) and its pop strobe
//   o_rdata / o_rdata_valid   captured read data, one pulse per read beat
//   o_done / o_err / o_timeout  one-cycle completion / abort status pulses
//   o_state                   IDLE=0, BURST=1, LAST=2 (for a bound checker)
//   o_wb_* / i_wb_*           Wishbone B3 master bus
module wb_burst_master #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MAX_BEATS   = 8,
  parameter int TIMEOUT_CYC = 1000,
  localparam int BW         = $clog2(MAX_BEATS) + 1,
  localparam int SW         = DW / 8
) (
  input  logic          i_clk,
  input  logic          quick_n_reset,
  input  logic          i_req,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_adr,
  input  logic [SW-1:0] i_req_sel,
  input  logic [BW-1:0] i_req_beats,
  input  logic [DW-1:0] i_wdata,
  output logic          o_wdata_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_rdata_valid,
  output logic          o_done,
  output logic          o_err,
  output logic          o_timeout,
  output logic [1:0]    o_state,
  output logic [AW-1:0] o_wb_adr,
  output logic [SW-1:0] o_wb_sel,
  output logic          o_wb_we,
  output logic [DW-1:0] o_wb_dat,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic [2:0]    o_wb_cti,
  output logic [1:0]    o_wb_bte,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_dat
);

  localparam int WW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_LAST  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] adr_reg, adr_next;
  logic [SW-1:0] sel_reg, sel_next;
  logic          we_reg, we_next;
  logic [BW-1:0] rem_reg, rem_next;
  logic          single_reg, single_next;
  logic [WW-1:0] wdog_reg, wdog_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          rdata_valid_reg, rdata_valid_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          timeout_reg, timeout_next;

  logic [BW-1:0] beats_eff;
  logic          active;

  // Zero means a single beat; anything above MAX_BEATS is clamped.
  always_comb begin
    if (i_req_beats == '0) begin
      beats_eff = BW'(1);
    end else if (i_req_beats > BW'(MAX_BEATS)) begin
      beats_eff = BW'(MAX_BEATS);
    end else begin
      beats_eff = i_req_beats;
    end
  end

  assign active = (state_reg != ST_IDLE);

  always_ff @(posedge i_clk or negedge quick_n_reset) begin
    if (!quick_n_reset) begin
      state_reg       <= ST_IDLE;
      adr_reg         <= '0;
      sel_reg         <= '0;
      we_reg          <= 1'b0;
      rem_reg         <= '0;
      single_reg      <= 1'b0;
      wdog_reg        <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      adr_reg         <= adr_next;
      sel_reg         <= sel_next;
      we_reg          <= we_next;
      rem_reg         <= rem_next;
      single_reg      <= single_next;
      wdog_reg        <= wdog_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      timeout_reg     <= timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    adr_next         = adr_reg;
    sel_next         = sel_reg;
    we_next          = we_reg;
    rem_next         = rem_reg;
    single_next      = single_reg;
    wdog_next        = wdog_reg;
    rdata_next       = rdata_reg;
    rdata_valid_next = 1'b0;
    done_next        = 1'b0;
    err_next         = 1'b0;
    timeout_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_req) begin
          adr_next    = i_req_adr;
          sel_next    = i_req_sel;
          we_next     = i_req_we;
          rem_next    = beats_eff;
          single_next = (beats_eff == BW'(1));
          wdog_next   = '0;
          state_next  = (beats_eff == BW'(1)) ? ST_LAST : ST_BURST;
        end
      end
      ST_BURST, ST_LAST: begin
        // Error takes priority over a simultaneous ack: the beat is not
        // counted as transferred.
        if (i_wb_err) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
          wdog_next  = '0;
        end else if (i_wb_ack) begin
          adr_next  = adr_reg + AW'(SW);
          rem_next  = rem_reg - BW'(1);
          wdog_next = '0;
          if (!we_reg) begin
            rdata_next       = i_wb_dat;
            rdata_valid_next = 1'b1;
          end
          if (state_reg == ST_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (rem_reg == BW'(2)) begin
            state_next = ST_LAST;
          end
        end else if (wdog_reg == WW'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th stalled strobe cycle.
          state_next   = ST_IDLE;
          err_next     = 1'b1;
          timeout_next = 1'b1;
          wdog_next    = '0;
        end else begin
          wdog_next = wdog_reg + WW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bus control follows the state register directly so that an asynchronous
  // reset drops cyc/stb without waiting for a clock edge.
  always_comb begin
    case (state_reg)
      ST_BURST: o_wb_cti = 3'b010;
      ST_LAST:  o_wb_cti = single_reg ? 3'b000 : 3'b111;
      default:  o_wb_cti = 3'b000;
    endcase
  end

  assign o_req_ready   = (state_reg == ST_IDLE);
  assign o_state       = state_reg;
  assign o_wb_cyc      = active;
  assign o_wb_stb      = active;
  assign o_wb_adr      = adr_reg;
  assign o_wb_sel      = sel_reg;
  assign o_wb_we       = we_reg;
  assign o_wb_bte      = 2'b00;
  assign o_wb_dat      = i_wdata;
  assign o_wdata_pop   = i_wb_ack & we_reg & active & ~i_wb_err;
  assign o_rdata       = rdata_reg;
  assign o_rdata_valid = rdata_valid_reg;
  assign o_done        = done_reg;
  assign o_err         = err_reg;
  assign o_timeout     = timeout_reg;

endmodule
